irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- External interrupt controller directly upstream of the coprocessor-0 exception unit.
- Synchronises 8 asynchronous device IRQ lines and applies per-line edge/level mode and masking.
- Raises the single external-interrupt request consumed by cop0 and tracks the accept/ERET handshake.
- Exposes mask, pending, mode and ID registers on the shared mtc0/mfc0 register bus.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each IRQ synchroniser; minimum 2.
- MASK_ADDR, 16, register address of the mask register.
- PEND_ADDR, 17, register address of the pending register.
- MODE_ADDR, 18, register address of the mode register; bit=1 edge, bit=0 level.
- ID_ADDR, 19, register address of the read-only ID register.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_irq  in  8  asynchronous device interrupt lines, active-high
- i_mtc0  in  1  register write strobe, shared with cop0
- i_address  in  5  register address, shared with cop0
- i_data  in  32  register write data
- i_exception_taken  in  1  cop0 exception-accept pulse; connects to cop0 o_exeption
- i_eret  in  1  return-from-exception pulse; same net as cop0 i_eret
- o_external_interrupt  out  1  request to cop0 i_external_interrupt
- o_irq_id  out  3  index of the line accepted most recently
- o_data  out  32  combinational register read data

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - synchronisers, edge history, pending, mask, mode and o_irq_id clear to 0; state=IDLE.
  - o_external_interrupt=0 and o_data=0 for any unmapped address.
  - Reset mid-request or mid-service abandons the interrupt silently.
- Synchroniser: each i_irq bit passes through SYNC_STAGES flops; s[i] is the last stage; s_d[i] is s[i] delayed one clock.
- Pending, level lines (mode[i]=0): pend[i] = s[i] registered one clock. It is not sticky; software clears it at the device.
- Pending, edge lines (mode[i]=1): pend[i] is sticky and is set on s[i] & ~s_d[i]. It is cleared by:
  - a PEND_ADDR write with data bit i = 1 (write-one-to-clear), or
  - acceptance of line i.
  - If set and clear fall in the same cycle, set wins.
- enabled = pend & mask. winner = lowest index set in enabled (line 0 has highest priority).
- FSM, next state registered on each clock:
  - IDLE: go to REQUEST if |enabled.
  - REQUEST: o_external_interrupt=1.
    - If i_exception_taken: latch o_irq_id=winner; clear pend[winner] if that line is edge mode; go to SERVICE.
    - Else if enabled==0 (level dropped, mask write, or W1C): go to IDLE.
  - SERVICE: o_external_interrupt=0; new pending events accumulate. On i_eret go to IDLE; IDLE re-requests on the next clock if |enabled.
- Ignored inputs: i_exception_taken in IDLE or SERVICE (the exception came from another source); i_eret in IDLE or REQUEST.
- Simultaneous i_exception_taken and register write in REQUEST: acceptance uses pend and mask as they were before the write; the write still takes effect in the same clock.
- Latency, SYNC_STAGES=2, i_irq high before clock edge 1, mask set, state IDLE: pend rises after edge 3; o_external_interrupt rises after edge 4 (SYNC_STAGES+2).
- Writes: on i_mtc0 with i_address equal to MASK_ADDR or MODE_ADDR, load i_data[7:0]; upper bits are ignored. A mode change from edge to level takes effect the next clock; the stored sticky bit is discarded.
- Reads (o_data, combinational, mux on i_address):
  - MASK_ADDR: {24'b0, mask}
  - PEND_ADDR: {24'b0, pend}
  - MODE_ADDR: {24'b0, mode}
  - ID_ADDR: {in_service, 28'b0, o_irq_id}, where in_service = (state==SERVICE)
  - any other address: 0, so cop0 addresses 12–14 are never driven by this block.
- o_irq_id holds its value until the next acceptance.

Test Plan:
- Reset, then mask=8'h01, mode=0; i_irq[0]=1 before edge 1 -> o_external_interrupt=1 after edge 4; pulse i_exception_taken -> SERVICE, o_irq_id=0, read ID_ADDR=32'h8000_0000; pulse i_eret -> IDLE, then REQUEST again next clock while i_irq[0] stays high.
- mode=8'hFF, mask=8'hFF; 1-cycle-wide pulses on i_irq[5] and i_irq[2] -> PEND read 8'h24; first accept gives o_irq_id=2 and pend=8'h20; after i_eret, second accept gives o_irq_id=5 and pend=8'h00.
- Edge line 3 pending in REQUEST; write 8'h08 to PEND_ADDR -> pend=0, o_external_interrupt drops next clock, state IDLE; i_exception_taken in that IDLE cycle -> no state change.
- In REQUEST, same-cycle i_exception_taken and MASK write 8'h00 -> accepted, o_irq_id captured, mask reads 0, state SERVICE.
- Edge line 1 accepted while a new edge on line 1 reaches the detector in the same cycle -> pend[1] stays 1 (set wins).
- Assert i_rst_n low in SERVICE with pend=8'h10 -> all registers 0, o_external_interrupt=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/irq_controller.sv
// External interrupt controller feeding the cop0 exception unit.
// Synchronises device lines, applies edge/level mode and mask, tracks accept/ERET.
module irq_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int MASK_ADDR   = 16,
  parameter int PEND_ADDR   = 17,
  parameter int MODE_ADDR   = 18,
  parameter int ID_ADDR     = 19
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_irq,
  input  logic        i_mtc0,
  input  logic [4:0]  i_address,
  input  logic [31:0] i_data,
  input  logic        i_exception_taken,
  input  logic        i_eret,
  output logic        o_external_interrupt,
  output logic [2:0]  o_irq_id,
  output logic [31:0] o_data
);

  localparam logic [4:0] A_MASK = MASK_ADDR[4:0];
  localparam logic [4:0] A_PEND = PEND_ADDR[4:0];
  localparam logic [4:0] A_MODE = MODE_ADDR[4:0];
  localparam logic [4:0] A_ID   = ID_ADDR[4:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] s, s_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mode_q;
  logic [7:0] enabled, rise;
  logic [7:0] w1c, acc_clr;
  logic [2:0] winner;
  logic       accept;
  logic       unused_data;

  assign unused_data = ^i_data[31:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      s_d    <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign enabled = pend_q & mask_q;

  // Descending scan leaves the lowest set index, giving line 0 top priority.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (enabled[i])
        winner = 3'(i);
  end

  assign accept = (state_q == REQUEST) && i_exception_taken;

  always_comb begin
    w1c = '0;
    if (i_mtc0 && (i_address == A_PEND))
      w1c = i_data[7:0];
  end

  always_comb begin
    acc_clr = '0;
    if (accept && mode_q[winner])
      acc_clr = 8'b1 << winner;
  end

  // Edge lines are sticky with set over clear; level lines track s.
  assign pend_d = (mode_q & (rise | (pend_q & ~(w1c | acc_clr))))
                | (~mode_q & s);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      o_irq_id <= '0;
    end else begin
      pend_q <= pend_d;
      if (i_mtc0 && (i_address == A_MASK))
        mask_q <= i_data[7:0];
      if (i_mtc0 && (i_address == A_MODE))
        mode_q <= i_data[7:0];
      if (accept)
        o_irq_id <= winner;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_external_interrupt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|enabled)
          state_d = REQUEST;
      end
      REQUEST: begin
        o_external_interrupt = 1'b1;
        if (i_exception_taken)
          state_d = SERVICE;
        else if (enabled == 8'd0)
          state_d = IDLE;
      end
      SERVICE: begin
        if (i_eret)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_data = '0;
    unique case (1'b1)
      (i_address == A_MASK): o_data = {24'd0, mask_q};
      (i_address == A_PEND): o_data = {24'd0, pend_q};
      (i_address == A_MODE): o_data = {24'd0, mode_q};
      (i_address == A_ID):
        o_data = {(state_q == SERVICE), 28'd0, o_irq_id};
      default: o_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_irq_controller;

  localparam logic [4:0] A_MASK = 5'd16;
  localparam logic [4:0] A_PEND = 5'd17;
  localparam logic [4:0] A_MODE = 5'd18;
  localparam logic [4:0] A_ID   = 5'd19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic        mtc0;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        exc;
  logic        eret;
  logic        ext;
  logic [2:0]  irq_id;
  logic [31:0] rdata;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_irq                (irq),
    .i_mtc0               (mtc0),
    .i_address            (addr),
    .i_data               (wdata),
    .i_exception_taken    (exc),
    .i_eret               (eret),
    .o_external_interrupt (ext),
    .o_irq_id             (irq_id),
    .o_data               (rdata)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(string tag, logic [4:0] a, logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
    addr = 5'd0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    mtc0  = 1'b1;
    addr  = a;
    wdata = d;
    step();
    mtc0  = 1'b0;
    addr  = 5'd0;
    wdata = '0;
  endtask

  task automatic pulse_exc();
    exc = 1'b1;
    step();
    exc = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    irq   = '0;
    mtc0  = 1'b0;
    addr  = '0;
    wdata = '0;
    exc   = 1'b0;
    eret  = 1'b0;
    #12;
    chk("rst_ext", {31'd0, ext}, 32'd0);
    chk("rst_id", {29'd0, irq_id}, 32'd0);
    rd("rst_mask", A_MASK, 32'd0);
    rd("rst_idreg", A_ID, 32'd0);
    rd("rst_unmapped", 5'd12, 32'd0);
    rst_n = 1'b1;
    step();

    // Level line 0: latency, accept, ERET, re-request
    wr(A_MASK, 32'hFFFF_FF01);
    rd("mask_upper_ignored", A_MASK, 32'h01);
    irq = 8'h01;
    step();
    step();
    step();
    rd("lvl_pend_e3", A_PEND, 32'h01);
    chk("lvl_ext_e3", {31'd0, ext}, 32'd0);
    step();
    chk("lvl_ext_e4", {31'd0, ext}, 32'd1);
    pulse_exc();
    chk("lvl_svc_ext", {31'd0, ext}, 32'd0);
    chk("lvl_svc_id", {29'd0, irq_id}, 32'd0);
    rd("lvl_svc_idreg", A_ID, 32'h8000_0000);
    rd("lvl_pend_stays", A_PEND, 32'h01);
    pulse_eret();
    chk("lvl_idle_ext", {31'd0, ext}, 32'd0);
    step();
    chk("lvl_rereq", {31'd0, ext}, 32'd1);
    irq = 8'h00;
    wr(A_MASK, 32'h00);
    step();
    chk("lvl_mask_drop", {31'd0, ext}, 32'd0);
    step();
    step();
    step();
    rd("lvl_pend_clear", A_PEND, 32'h00);

    // Edge pulses on lines 5 and 2: priority and clear on accept
    wr(A_MODE, 32'hFF);
    wr(A_MASK, 32'hFF);
    irq = 8'h24;
    step();
    irq = 8'h00;
    step();
    step();
    step();
    rd("edge_pend24", A_PEND, 32'h24);
    chk("edge_ext", {31'd0, ext}, 32'd1);
    pulse_exc();
    chk("edge_id2", {29'd0, irq_id}, 32'd2);
    rd("edge_pend20", A_PEND, 32'h20);
    pulse_eret();
    step();
    chk("edge_rereq", {31'd0, ext}, 32'd1);
    pulse_exc();
    chk("edge_id5", {29'd0, irq_id}, 32'd5);
    rd("edge_pend00", A_PEND, 32'h00);
    pulse_eret();
    step();
    chk("edge_idle", {31'd0, ext}, 32'd0);

    // W1C of line 3 while requesting; exception in IDLE ignored
    irq = 8'h08;
    step();
    irq = 8'h00;
    step();
    step();
    step();
    chk("w1c_req", {31'd0, ext}, 32'd1);
    wr(A_PEND, 32'h08);
    rd("w1c_pend", A_PEND, 32'h00);
    step();
    chk("w1c_drop", {31'd0, ext}, 32'd0);
    pulse_exc();
    chk("idle_exc_ext", {31'd0, ext}, 32'd0);
    rd("idle_exc_idreg", A_ID, 32'h0000_0005);

    // Accept together with a mask write of 0
    irq = 8'h40;
    step();
    irq = 8'h00;
    step();
    step();
    step();
    chk("acc_mask_req", {31'd0, ext}, 32'd1);
    exc   = 1'b1;
    mtc0  = 1'b1;
    addr  = A_MASK;
    wdata = 32'h00;
    step();
    exc   = 1'b0;
    mtc0  = 1'b0;
    wdata = '0;
    rd("acc_mask_idreg", A_ID, 32'h8000_0006);
    rd("acc_mask_mask", A_MASK, 32'h00);
    rd("acc_mask_pend", A_PEND, 32'h00);
    pulse_eret();
    wr(A_MASK, 32'hFF);

    // New edge on line 1 lands on the accept clock: set wins
    irq = 8'h02;
    step();
    irq = 8'h00;
    step();
    irq = 8'h02;
    step();
    irq = 8'h00;
    step();
    chk("setwin_req", {31'd0, ext}, 32'd1);
    pulse_exc();
    rd("setwin_pend", A_PEND, 32'h02);
    rd("setwin_idreg", A_ID, 32'h8000_0001);
    pulse_eret();
    step();
    chk("setwin_rereq", {31'd0, ext}, 32'd1);
    pulse_exc();
    rd("setwin_pend0", A_PEND, 32'h00);

    // Async reset in SERVICE with pend=8'h10
    irq = 8'h10;
    step();
    irq = 8'h00;
    step();
    step();
    step();
    rd("svc_pend10", A_PEND, 32'h10);
    chk("svc_noreq", {31'd0, ext}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ext", {31'd0, ext}, 32'd0);
    chk("arst_id", {29'd0, irq_id}, 32'd0);
    rd("arst_mask", A_MASK, 32'd0);
    rd("arst_mode", A_MODE, 32'd0);
    rd("arst_pend", A_PEND, 32'd0);
    rd("arst_idreg", A_ID, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, ext}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
